// File: rtl/pc_sequencer_if.sv
// Fetch-control bus between the pipeline and the PC sequencer.
// The pipeline (master) drives the stage requests; the sequencer (slave) drives pc and flush controls.
interface pc_sequencer_if;
  logic        stall;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [15:0] immediate;
  logic        jump_valid;
  logic [25:0] jump_index;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        redirect;
  logic        addr_err;

  modport master (
    output stall, branch_valid, branch_taken, branch_pc, immediate, jump_valid, jump_index,
    input  pc, pc_plus4, if_id_write, if_id_flush, id_ex_flush, redirect, addr_err
  );

  modport slave (
    input  stall, branch_valid, branch_taken, branch_pc, immediate, jump_valid, jump_index,
    output pc, pc_plus4, if_id_write, if_id_flush, id_ex_flush, redirect, addr_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC register and next-fetch selection: taken branch > jump > stall > sequential,
// plus IF/ID / ID/EX squash controls and a multi-cycle IF/ID flush window after redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input logic         clk,
  input logic         rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [1:0] RELOAD = 2'(FLUSH_CYCLES - 1);
  localparam bit         MULTI  = (FLUSH_CYCLES > 1);

  state_t      state_reg, state_next;
  logic [1:0]  count_reg, count_next;
  logic [31:0] pc_reg, pc_next;
  logic        addr_err_reg, addr_err_next;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        take_branch;
  logic        take_jump;
  logic        redirect;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;

  assign pc_plus4      = pc_reg + 32'd4;
  assign branch_target = bus.branch_pc + 32'd4 + {{14{bus.immediate[15]}}, bus.immediate, 2'b00};
  assign jump_target   = {pc_plus4[31:28], bus.jump_index, 2'b00};
  assign take_branch   = bus.branch_valid & bus.branch_taken;
  // The ID-stage jump is itself being flushed while in FLUSH, so it must not redirect.
  assign take_jump     = bus.jump_valid & (state_reg == RUN) & ~take_branch;
  assign redirect      = take_branch | take_jump;

  always_comb begin
    pc_next       = pc_plus4;
    if_id_write   = 1'b1;
    if_id_flush   = (state_reg == FLUSH);
    id_ex_flush   = 1'b0;
    addr_err_next = addr_err_reg;
    state_next    = state_reg;
    count_next    = count_reg;

    if (take_branch) begin
      pc_next     = branch_target;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (take_jump) begin
      pc_next     = jump_target;
      if_id_flush = 1'b1;
    end else if (bus.stall) begin
      pc_next     = pc_reg;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end

    // Misaligned targets are still loaded; the error is only recorded.
    if (redirect && (pc_next[1:0] != 2'b00))
      addr_err_next = 1'b1;

    case (state_reg)
      RUN: begin
        if (redirect && MULTI) begin
          state_next = FLUSH;
          count_next = RELOAD;
        end
      end
      FLUSH: begin
        if (take_branch) begin
          count_next = RELOAD;
        end else if (count_reg <= 2'd1) begin
          state_next = RUN;
          count_next = 2'd0;
        end else begin
          count_next = count_reg - 2'd1;
        end
      end
      default: begin
        state_next = RUN;
        count_next = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      count_reg    <= 2'd0;
      pc_reg       <= RESET_PC;
      addr_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      pc_reg       <= pc_next;
      addr_err_reg <= addr_err_next;
    end
  end

  assign bus.pc          = pc_reg;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.if_id_write = if_id_write;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.redirect    = redirect;
  assign bus.addr_err    = addr_err_reg;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-address controller for the 5-stage pipeline. Owns the PC register and selects each cycle between sequential fetch, conditional-branch redirect, jump redirect and hazard stall. Branch targets use the sign-extended 16-bit offset scaled by 4, added to the branch PC + 4. The block drives the IF/ID and ID/EX flush and write-enable controls that squash wrong-path instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset
- FLUSH_CYCLES, 1, IF/ID flush cycles after a redirect (legal range 1..3)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hazard-unit hold request (load-use)
- branch_valid  in  1  EX stage holds a conditional branch this cycle
- branch_taken  in  1  branch condition result; ignored unless branch_valid
- branch_pc  in  32  address of the branch instruction in EX
- immediate  in  16  raw branch offset field, in words
- jump_valid  in  1  ID stage holds a J-type jump this cycle
- jump_index  in  26  jump target field
- pc  out  32  current fetch address (registered)
- pc_plus4  out  32  pc + 4, combinational
- if_id_write  out  1  IF/ID register load enable
- if_id_flush  out  1  clear IF/ID to NOP at next edge
- id_ex_flush  out  1  clear ID/EX to NOP at next edge
- redirect  out  1  single-cycle pulse: pc loads a non-sequential target at next edge
- addr_err  out  1  sticky: a redirect target was not word-aligned

## Operation
- Branch target: branch_pc + 4 + {{14{immediate[15]}}, immediate, 2'b00}, modulo 2^32 (wrap-around, no overflow flag).
- Jump target: {pc_plus4[31:28], jump_index, 2'b00}.
- Next-PC priority, highest first: taken branch (branch_valid & branch_taken) > jump_valid > stall > pc + 4.
- Taken branch: pc <= branch target; redirect=1, if_id_flush=1, id_ex_flush=1 in the same cycle. A simultaneous jump and stall are discarded, since both are on the wrong path.
- Jump (no taken branch): pc <= jump target; redirect=1, if_id_flush=1, id_ex_flush=0. A simultaneous stall is overridden.
- Stall (no redirect): pc holds, if_id_write=0, id_ex_flush=1 (inserts a bubble), if_id_flush=0.
- Otherwise: pc <= pc + 4; if_id_write=1; both flushes 0.
- Not-taken branch (branch_valid & !branch_taken) behaves as sequential fetch.
- addr_err sets when a selected redirect target has bits [1:0] != 0. It clears only on reset. The pc still loads the unaligned value.
- FSM states:
  - RUN: the redirect cycle itself is handled in RUN. On a redirect with FLUSH_CYCLES>1, go to FLUSH with count = FLUSH_CYCLES-1.
  - FLUSH: if_id_flush=1 every cycle; pc advances as in RUN (stall honoured); count decrements each cycle; at count==1 return to RUN.
  - A taken branch during FLUSH redirects again and reloads count = FLUSH_CYCLES-1.
  - A jump during FLUSH is ignored, because the ID instruction is flushed. pc advances sequentially.

## Timing
- Reset (rst_n=0, asynchronous): pc=RESET_PC, state=RUN, count=0, addr_err=0. Combinational outputs follow from these values, so redirect=0, flushes=0, if_id_write=1 (when stall=0).
- First fetch after release is RESET_PC. The first pc update occurs at the first rising edge with rst_n=1.
- Redirect latency: the decision is combinational in cycle N; pc equals the target in cycle N+1. No extra cycles.
- Reset asserted mid-FLUSH aborts the flush immediately.
- All control outputs except pc and addr_err are combinational from inputs and state. They must be stable before the edge, with no registered delay.

## Test plan
- Reset: hold rst_n=0 with RESET_PC=32'h0000_0040, release, run 3 cycles with no events -> pc = 0x40, 0x44, 0x48; all flushes 0.
- Backward branch: branch_pc=0x100, immediate=16'hFFFC, taken, single cycle -> next pc=0x0F4; redirect, if_id_flush and id_ex_flush high for exactly that cycle.
- Priority: in one cycle, taken branch (pc 0x200, imm 0x0003) + jump_valid (index 0x000_0040) + stall -> pc=0x210; jump and stall ignored; id_ex_flush=1.
- Stall then jump: stall=1 for 2 cycles at pc=0x80 -> pc holds 0x80, if_id_write=0, id_ex_flush=1. Then jump_index=26'h0000_100 -> pc=0x400, if_id_flush=1, id_ex_flush=0.
- FLUSH_CYCLES=3: taken branch to 0x300 -> if_id_flush high for 3 consecutive cycles. A jump in the 2nd cycle is ignored (pc 0x304, then 0x308). A second taken branch in the 3rd cycle restarts the 3-cycle flush.
- Wrap and alignment: branch_pc=0xFFFF_FFF8, imm=0x0002 -> pc=0x0000_0004, addr_err=0. branch_pc=0x101, taken -> addr_err=1 and stays 1 until rst_n low.
